// File: rtl/pc_addr_gen.sv
// -----------------------------------------------------------------------------
// pc_addr_gen
//
// Next-PC candidate generator for the multicycle MIPS CPU. It sits between the
// PC register and the PC-select mux. Every cycle it computes three candidate
// next-PC values from the current PC and the instruction fields, and registers
// them. The control FSM elsewhere picks one; this block holds no selection
// state.
//
// There is no enable and no handshake. All inputs are treated as stable around
// the rising clock edge, and the outputs update every cycle with 1-cycle
// latency. A synchronous, active-high reset has priority over the update.
//
// Ports:
//   clk           in   1   system clock; all outputs update on the rising edge
//   reset         in   1   synchronous, active-high; loads RESET_VAL
//   address       in  26   instruction[25:0], J-format target field
//   immediate     in  16   instruction[15:0], I-format offset
//   opcode        in   6   instruction[31:26]
//   R_rs          in  32   contents of register rs (jr target)
//   PC            in  32   current program counter
//   PC4           out 32   registered PC + 4
//   branchAddress out 32   registered PC + 4 + (sign_extend(immediate) << 2)
//   jumpAddress   out 32   registered jr target (opcode 0) or pseudo-direct
//                          J-format target
//   misaligned    out  1   only when PCADDR_ALIGN_CHECK_EN is defined:
//                          registered flag, set for opcode 0 when R_rs[1:0] is
//                          non-zero; it resets to 0
//
// Optional feature macro: PCADDR_ALIGN_CHECK_EN
//   Defined   : adds the misaligned output. jumpAddress is not masked.
//   Undefined : the port and its logic do not exist.
//
// Parameters:
//   RESET_VAL  value loaded into PC4, branchAddress and jumpAddress on reset
// -----------------------------------------------------------------------------
module pc_addr_gen #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [25:0] address,
    input  logic [15:0] immediate,
    input  logic [5:0]  opcode,
    input  logic [31:0] R_rs,
    input  logic [31:0] PC,
    output logic [31:0] PC4,
    output logic [31:0] branchAddress,
    output logic [31:0] jumpAddress
`ifdef PCADDR_ALIGN_CHECK_EN
    ,
    output logic        misaligned
`endif
);

    // R-type opcode; jr is the only R-type instruction that reaches this path.
    localparam logic [5:0] OPCODE_RTYPE = 6'b000000;

    logic [31:0] pc4_d,    pc4_q;
    logic [31:0] branch_d, branch_q;
    logic [31:0] jump_d,   jump_q;
    logic [31:0] branch_offset;

    // Next-value computation. All additions wrap modulo 2^32, and no overflow
    // is reported.
    always_comb begin
        pc4_d         = PC + 32'd4;

        // The immediate is sign-extended and then shifted left by two, so
        // 16'hFFFF becomes an offset of -4.
        branch_offset = {{14{immediate[15]}}, immediate, 2'b00};
        branch_d      = pc4_d + branch_offset;

        // The pseudo-direct region comes from the upper nibble of PC + 4, not
        // of PC. This only matters when PC is the last word of a 256 MB
        // region. The value is computed for every opcode so the register
        // contents are always defined.
        if (opcode == OPCODE_RTYPE) begin
            jump_d = R_rs;
        end else begin
            jump_d = {pc4_d[31:28], address, 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc4_q    <= RESET_VAL;
            branch_q <= RESET_VAL;
            jump_q   <= RESET_VAL;
        end else begin
            pc4_q    <= pc4_d;
            branch_q <= branch_d;
            jump_q   <= jump_d;
        end
    end

    assign PC4           = pc4_q;
    assign branchAddress = branch_q;
    assign jumpAddress   = jump_q;

`ifdef PCADDR_ALIGN_CHECK_EN
    // Flags a jr whose target is not word-aligned. The target is passed
    // through unmodified, and the consumer decides how to handle the flag.
    logic misaligned_d, misaligned_q;

    always_comb begin
        misaligned_d = (opcode == OPCODE_RTYPE) && (R_rs[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    assign misaligned = misaligned_q;
`endif

endmodule

// File: tb/tb_pc_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_addr_gen
//
// Self-checking bench for pc_addr_gen. Expected values come from a reference
// model written with plain arithmetic: a signed multiply for the offset and a
// mask-and-or for the jump region. Each step pushes the expected results into
// exp_q. After the next rising edge the step pops them and compares them with
// the outputs.
// -----------------------------------------------------------------------------
module tb_pc_addr_gen;

    logic        clk;
    logic        reset;
    logic [25:0] address;
    logic [15:0] immediate;
    logic [5:0]  opcode;
    logic [31:0] R_rs;
    logic [31:0] PC;
    logic [31:0] PC4;
    logic [31:0] branchAddress;
    logic [31:0] jumpAddress;
`ifdef PCADDR_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];

    pc_addr_gen dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .immediate     (immediate),
        .opcode        (opcode),
        .R_rs          (R_rs),
        .PC            (PC),
        .PC4           (PC4),
        .branchAddress (branchAddress),
        .jumpAddress   (jumpAddress)
`ifdef PCADDR_ALIGN_CHECK_EN
        ,
        .misaligned    (misaligned)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model(input logic rst, input logic [25:0] a, input logic [15:0] imm,
                         input logic [5:0] op, input logic [31:0] rs, input logic [31:0] pc);
        logic [31:0] e_pc4, e_br, e_j, e_mis;
        int          off;
        if (rst) begin
            e_pc4 = 32'h0;
            e_br  = 32'h0;
            e_j   = 32'h0;
            e_mis = 32'h0;
        end else begin
            e_pc4 = pc + 32'd4;
            off   = int'($signed(imm)) * 4;
            e_br  = e_pc4 + 32'(off);
            if (op == 6'd0) e_j = rs;
            else            e_j = (e_pc4 & 32'hF000_0000) | (32'(a) << 2);
            e_mis = ((op == 6'd0) && (rs % 4 != 0)) ? 32'd1 : 32'd0;
        end
        exp_q.push_back(e_pc4);
        exp_q.push_back(e_br);
        exp_q.push_back(e_j);
        exp_q.push_back(e_mis);
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 time unit after a rising edge. Outputs are sampled
    // 1 time unit after the following rising edge.
    task automatic step(input string tag, input logic rst, input logic [25:0] a,
                        input logic [15:0] imm, input logic [5:0] op,
                        input logic [31:0] rs, input logic [31:0] pc);
        logic [31:0] e_mis;
        reset     = rst;
        address   = a;
        immediate = imm;
        opcode    = op;
        R_rs      = rs;
        PC        = pc;
        model(rst, a, imm, op, rs, pc);
        @(posedge clk);
        #1;
        check({tag, ".pc4"},    PC4,           exp_q.pop_front());
        check({tag, ".branch"}, branchAddress, exp_q.pop_front());
        check({tag, ".jump"},   jumpAddress,   exp_q.pop_front());
        e_mis = exp_q.pop_front();
`ifdef PCADDR_ALIGN_CHECK_EN
        check({tag, ".mis"}, {31'd0, misaligned}, e_mis);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] hold_pc4, hold_br, hold_j;
        logic [5:0]  op_r;
        logic [31:0] pc_r;

        reset = 1'b1; address = '0; immediate = '0; opcode = '0; R_rs = '0; PC = '0;
        @(posedge clk);
        #1;

        // Reset with arbitrary inputs applied.
        step("reset", 1'b1, 26'h2AB_CDEF, 16'h8123, 6'h2, 32'hDEAD_BEEF, 32'h1234_5678);

        // Directed cases.
        step("rtype",  1'b0, 26'h3, 16'h3, 6'h0, 32'h5, 32'h0);
        step("jfmt",   1'b0, 26'h3, 16'h3, 6'h2, 32'h5, 32'h0);
        step("negbr",  1'b0, 26'h155_5555, 16'hFFFF, 6'h4, 32'h0, 32'h1000_0000);
        step("wrap",   1'b0, 26'h3FF_FFFF, 16'h0001, 6'h2, 32'h0, 32'hFFFF_FFFC);
        step("region", 1'b0, 26'h000_0001, 16'h8000, 6'h3, 32'h0, 32'h0FFF_FFFC);
        step("misal",  1'b0, 26'h0, 16'h0, 6'h0, 32'h6, 32'h40);

        // Latency: changing the inputs mid-cycle must not move the outputs.
        hold_pc4 = PC4; hold_br = branchAddress; hold_j = jumpAddress;
        step("lat_a", 1'b0, 26'h12_3456, 16'h0010, 6'h2, 32'h0, 32'h0000_1000);
        PC = 32'h7777_0000; immediate = 16'h4444; opcode = 6'h0; R_rs = 32'hABCD_0000;
        #2;
        check("lat.pc4_hold",    PC4,           32'h0000_1004);
        check("lat.branch_hold", branchAddress, 32'h0000_1044);
        check("lat.jump_hold",   jumpAddress,   32'h0048_D158);
        check("lat.prev_differs", {31'd0, (hold_pc4 == PC4)}, 32'd0);
        step("lat_b", 1'b0, 26'h0, 16'h4444, 6'h0, 32'hABCD_0000, 32'h7777_0000);

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       op_r = 6'h0;
                1:       op_r = 6'h2;
                2:       op_r = 6'h4;
                default: op_r = 6'($urandom());
            endcase
            if ($urandom_range(0, 7) == 0) pc_r = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
            else if ($urandom_range(0, 7) == 0) pc_r = {4'($urandom()), 28'hFFF_FFFC};
            else pc_r = $urandom() & 32'hFFFF_FFFC;
            step("rand", ($urandom_range(0, 19) == 0), 26'($urandom()), 16'($urandom()),
                 op_r, $urandom(), pc_r);
        end

        // Reset asserted mid-stream clears everything, then recovery.
        step("midrst",  1'b1, 26'h1, 16'h1, 6'h0, 32'h3, 32'h100);
        step("recover", 1'b0, 26'h1, 16'h1, 6'h0, 32'h3, 32'h100);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/pc_addr_gen.md
Name: pc_addr_gen

Overview:
- Next-PC candidate generator for the multicycle MIPS CPU; sits between the PC register and the PC-select mux.
- From the current PC and instruction fields it computes three registered candidates: sequential (PC+4), conditional branch target, and jump target.
- The jump target is the register value for R-type (jr) or the pseudo-direct target for J-format.
- Control FSM picks among the outputs; this block holds no selection state.

Parameters:
- RESET_VAL, 32'h0000_0000, value loaded into every output register on reset.

Ports:
- clk  input  1  system clock; all outputs update on rising edge
- reset  input  1  synchronous, active-high reset
- address  input  26  instruction[25:0], J-format target field
- immediate  input  16  instruction[15:0], I-format offset
- opcode  input  6  instruction[31:26]
- R_rs  input  32  contents of register rs
- PC  input  32  current program counter
- PC4  output  32  registered PC+4
- branchAddress  output  32  registered branch target
- jumpAddress  output  32  registered jump target

Behaviour:
- All outputs are registered with 1-cycle latency: values sampled at posedge N appear after posedge N and hold until posedge N+1.
- Reset is synchronous, checked at posedge, and has priority over the update. While reset=1 at a posedge, PC4, branchAddress and jumpAddress all load RESET_VAL.
- Combinational next values (mod 2^32, no overflow flag):
  - pc4_n = PC + 32'd4
  - branch_n = pc4_n + ({{14{immediate[15]}}, immediate, 2'b00})
  - jump_n = (opcode == 6'b000000) ? R_rs : {pc4_n[31:28], address, 2'b00}
- Immediate is sign-extended before the shift, so 16'hFFFF yields an offset of -4.
- Wrap-around: PC=32'hFFFF_FFFC gives PC4=0; branch addition also wraps.
- The jump region uses the upper nibble of PC+4, not PC. At PC=32'h0FFF_FFFC, PC+4[31:28]=4'h1.
- jumpAddress is computed on every cycle regardless of instruction type. For non-jump opcodes it is don't-care to the consumer but still deterministic per the formula above.
- All inputs are treated as stable around the posedge. There is no enable and no handshake; the block updates every cycle.

Optional Feature:
- Macro: PCADDR_ALIGN_CHECK_EN
- When defined:
  - Adds output port misaligned (1 bit, registered, same latency, reset to 0).
  - misaligned = 1 when opcode==6'b000000 and R_rs[1:0]!=2'b00; otherwise 0.
  - jumpAddress behaviour is unchanged (the value is not masked).
- When undefined: the port does not exist and no logic is generated.

Test Plan:
- Reset: reset=1 at a posedge with arbitrary inputs -> PC4=branchAddress=jumpAddress=0. Reset asserted mid-stream also clears all outputs at the next posedge.
- R-type jump: address=26'h3, immediate=16'h3, opcode=0, R_rs=5, PC=0 -> after posedge: PC4=32'h4, branchAddress=32'h10, jumpAddress=32'h5.
- J-format jump: same inputs with opcode=6'h2 -> PC4=32'h4, branchAddress=32'h10, jumpAddress=32'hC.
- Negative branch and region: PC=32'h1000_0000, immediate=16'hFFFF, opcode=6'h4 -> PC4=32'h1000_0004, branchAddress=32'h1000_0000, jumpAddress={4'h1, address, 2'b00}.
- Wrap: PC=32'hFFFF_FFFC, immediate=16'h0001, opcode=6'h2, address=26'h3FF_FFFF -> PC4=0, branchAddress=32'h4, jumpAddress=32'h0FFF_FFFC.
- Latency: change inputs mid-cycle -> outputs stay unchanged until the next posedge. With PCADDR_ALIGN_CHECK_EN, opcode=0 and R_rs=32'h6 -> misaligned=1.
